// File: rtl/fifo_pkg.sv
// Shared types and defaults for the fifo block.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF      = 18;
  localparam int unsigned FIFO_DEPTH_LOG2_DEF = 4;

  // Accepted-access kind for a cycle, encoded as {push_ok, pop_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read port.
// The read register is reset so the FIFO output starts at zero; the array is not.
module fifo_mem #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: read-before-write, so a same-address write returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Circular FIFO: pointers, occupancy counter, registered status and sticky error flags.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH      = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [FIFO_WIDTH-1:0]    i_data,
  output logic [FIFO_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [FIFO_DEPTH_LOG2:0] o_count,
  output logic                     o_overflow,
  output logic                     o_underflow,
  input  logic                     i_clr_err
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, valid_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push_ok, pop_ok;
  fifo_op_e         op;

  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign push_ok = i_push && (!full_q || i_pop);
  assign pop_ok  = i_pop && !empty_q;
  assign op      = fifo_op_e'({push_ok, pop_ok});

  // Next-state pointers, occupancy and sticky flags; a new error wins over a clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (op)
      OP_PUSH: count_d = count_q + 1'b1;
      OP_POP:  count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = (i_push && !push_ok) || (ovf_q && !i_clr_err);
    unf_d = (i_pop && !pop_ok)   || (unf_q && !i_clr_err);
  end

  // State register; full/empty are registered from next-state count to align with o_count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      valid_q  <= pop_ok;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH  (FIFO_WIDTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_data),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (o_data)
  );

  assign o_valid     = valid_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

`ifdef FORMAL
  logic pop_ok_past_q;

  // Remembers whether the previous cycle accepted a pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pop_ok_past_q <= 1'b0;
    else          pop_ok_past_q <= pop_ok;
  end

  a_ptr_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    full_q || (count_q == CNT_W'(PTR_W'(wr_ptr_q - rd_ptr_q))));
  a_not_full_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(full_q && empty_q));
  a_count_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= DEPTH_C);
  a_valid_pop: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    valid_q |-> pop_ok_past_q);
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo against a queue-based reference model.
module tb_fifo;

  localparam int W = 18;
  localparam int L = 4;
  localparam int D = 16;
  localparam int VW = 1 + W + (L + 1) + 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] o_data;
  logic         o_valid, o_full, o_empty, o_overflow, o_underflow;
  logic [L:0]   o_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_data = '0;
  logic         m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH_LOG2(L)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (push),
    .i_pop       (pop),
    .i_data      (din),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .i_clr_err   (clr)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec();
    logic [L:0] c;
    c = (L+1)'(q.size());
    return {m_valid, m_data, c, (q.size() == D), (q.size() == 0), m_ovf, m_unf};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {o_valid, o_data, o_count, o_full, o_empty, o_overflow, o_underflow};
  endfunction

  // One clock of stimulus; model advances by the FIFO rules, outputs sampled 1 time unit after the edge.
  task automatic cycle(input logic p, input logic r, input logic [W-1:0] d, input logic c);
    bit push_ok, pop_ok;
    push = p; pop = r; din = d; clr = c;
    push_ok = p && ((q.size() < D) || r);
    pop_ok  = r && (q.size() > 0);
    @(posedge clk); #1;
    m_valid = 1'b0;
    if (pop_ok) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end
    if (push_ok) q.push_back(d);
    m_ovf = (p && !push_ok) || (m_ovf && !c);
    m_unf = (r && !pop_ok)  || (m_unf && !c);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (obs_vec() !== {1'b0, {W{1'b0}}, {(L+1){1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected valid=0 data=0 count=0 full=0 empty=1 flags=0", obs_vec());
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, W'(i), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_push: got %h expected %h", obs_vec(), exp_vec()); end
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== W'(i)) begin
        errors++; $display("FAIL basic_pop: got valid=%b data=%h expected valid=1 data=%h", o_valid, o_data, W'(i));
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL basic_pop_state: got %h expected %h", obs_vec(), exp_vec()); end
    end
    checks++;
    if (o_empty !== 1'b1 || o_count !== '0) begin
      errors++; $display("FAIL basic_drained: got empty=%b count=%0d expected empty=1 count=0", o_empty, o_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'(i), 1'b0);
    checks++;
    if (o_full !== 1'b1 || o_count !== (L+1)'(D)) begin
      errors++; $display("FAIL full_after_16: got full=%b count=%0d expected full=1 count=16", o_full, o_count);
    end
    cycle(1'b1, 1'b0, 18'h3FFFF, 1'b0);
    checks++;
    if (o_overflow !== 1'b1 || o_count !== (L+1)'(D)) begin
      errors++; $display("FAIL overflow: got ovf=%b count=%0d expected ovf=1 count=16", o_overflow, o_count);
    end
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (o_data !== W'(i) || o_valid !== 1'b1) begin
        errors++; $display("FAIL overflow_drain: got %h expected %h", o_data, W'(i));
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL clr_ovf: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'(i), 1'b0);
    cycle(1'b1, 1'b1, 18'h2AAAA, 1'b0);
    checks++;
    if (o_data !== '0 || o_valid !== 1'b1 || o_full !== 1'b1 || o_overflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop: got data=%h valid=%b full=%b ovf=%b expected 0 1 1 0", o_data, o_valid, o_full, o_overflow);
    end
    for (int i = 1; i <= D; i++) begin
      cycle(1'b0, 1'b1, '0, 1'b0);
      checks++;
      if (o_data !== ((i == D) ? 18'h2AAAA : W'(i))) begin
        errors++; $display("FAIL full_pushpop_drain: got %h at pop %0d", o_data, i);
      end
    end
  endtask

  task automatic test_empty_pushpop();
    cycle(1'b1, 1'b1, 18'h15555, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_underflow !== 1'b1 || o_count !== 5'd1) begin
      errors++; $display("FAIL empty_pushpop: got valid=%b unf=%b count=%0d expected 0 1 1", o_valid, o_underflow, o_count);
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (o_data !== 18'h15555 || o_valid !== 1'b1) begin
      errors++; $display("FAIL empty_pushpop_read: got %h expected 15555", o_data);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (o_underflow !== 1'b0) begin errors++; $display("FAIL clr_unf: got %b expected 0", o_underflow); end
    // New error coinciding with clear: flag stays set.
    cycle(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (o_underflow !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", o_underflow); end
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 3; n++) cycle(1'b1, 1'b0, W'(n + 100), 1'b0);
    for (int n = 3; n < 43; n++) begin
      cycle(1'b1, 1'b1, W'(n + 100), 1'b0);
      checks++;
      if (o_data !== W'(n + 97) || o_valid !== 1'b1 || o_count !== 5'd3) begin
        errors++; $display("FAIL wrap: got data=%h count=%0d expected data=%h count=3", o_data, o_count, W'(n + 97));
      end
    end
    repeat (3) cycle(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom % 100) < 55, ($urandom % 100) < 45, W'($urandom), ($urandom % 16) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, W'(i + 50), 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_valid !== 1'b0 || o_data !== '0) begin
      errors++; $display("FAIL async_reset: got count=%0d empty=%b valid=%b data=%h expected 0 1 0 0", o_count, o_empty, o_valid, o_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 18'h00007, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (o_data !== 18'h00007 || o_valid !== 1'b1 || o_empty !== 1'b1) begin
      errors++; $display("FAIL after_reset: got data=%h valid=%b empty=%b expected 7 1 1", o_data, o_valid, o_empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
